// File: rtl/adjust_pulse_gen_pkg.sv
// Shared types and defaults for the set-button step pulse generator.
// Button vectors are ordered {up, dn}.
package adjust_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCK   = 2'd3
  } state_e;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  localparam int DEF_DB_CYCLES     = 20;
  localparam int DEF_HOLD_CYCLES   = 500;
  localparam int DEF_REPEAT_CYCLES = 100;
  localparam int DEF_CNT_BITS      = 10;

  localparam logic [1:0] BTN_NONE = 2'b00;
  localparam logic [1:0] BTN_DN   = 2'b01;
  localparam logic [1:0] BTN_UP   = 2'b10;
  localparam logic [1:0] BTN_BOTH = 2'b11;

  function automatic logic [1:0] dir_pattern(
    input dir_e d
  );
    return (d == DIR_UP) ? BTN_UP : BTN_DN;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability filter.
// The output follows the synced vector once it held for DB_CYCLES.
module btn_debounce #(
  parameter int WIDTH     = 2,
  parameter int DB_CYCLES = 20,
  parameter int CNT_BITS  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o
);

  localparam logic [CNT_BITS-1:0] CNT_MAX =
    CNT_BITS'(DB_CYCLES - 1);

  logic [WIDTH-1:0]    s1_q;
  logic [WIDTH-1:0]    s2_q;
  logic [WIDTH-1:0]    stable_q;
  logic [WIDTH-1:0]    stable_d;
  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;

  // s1 differing from s2 means the candidate changes on this edge
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (s1_q != s2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
    if (cnt_q == CNT_MAX) begin
      stable_d = s2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/adjust_pulse_gen.sv
// Step strobe generator for set mode: one strobe per press,
// auto-repeat after a long hold, lockout on ambiguous input.
module adjust_pulse_gen
  import adjust_pulse_gen_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_BITS      = DEF_CNT_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn_up,
  input  logic btn_dn,
  output logic c,
  output logic cu,
  output logic cd,
  output logic rpt
);

  localparam logic [CNT_BITS-1:0] HOLD_MAX =
    CNT_BITS'(HOLD_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] RPT_MAX =
    CNT_BITS'(REPEAT_CYCLES - 1);

  logic [1:0]          stable;
  state_e              state_q;
  state_e              state_d;
  dir_e                dir_q;
  dir_e                dir_d;
  logic [CNT_BITS-1:0] tmr_q;
  logic [CNT_BITS-1:0] tmr_d;
  logic                en_q;
  logic                strobe;
  logic                c_q;
  logic                cu_q;
  logic                cd_q;
  logic                rpt_q;

  btn_debounce #(
    .WIDTH     (2),
    .DB_CYCLES (DB_CYCLES),
    .CNT_BITS  (CNT_BITS)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .raw_i    ({btn_up, btn_dn}),
    .stable_o (stable)
  );

  // A press already present when en rises is treated as ambiguous
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    strobe  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (stable != BTN_NONE) begin
            if (!en_q || stable == BTN_BOTH) begin
              state_d = ST_LOCK;
            end else begin
              state_d = ST_HOLD;
              dir_d   = (stable == BTN_UP) ? DIR_UP : DIR_DN;
              strobe  = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (stable == BTN_NONE) begin
            state_d = ST_IDLE;
          end else if (stable != dir_pattern(dir_q)) begin
            state_d = ST_LOCK;
          end else if (tmr_q == HOLD_MAX) begin
            state_d = ST_REPEAT;
            strobe  = 1'b1;
          end
        end
        ST_REPEAT: begin
          if (stable == BTN_NONE) begin
            state_d = ST_IDLE;
          end else if (stable != dir_pattern(dir_q)) begin
            state_d = ST_LOCK;
          end else if (tmr_q == RPT_MAX) begin
            strobe = 1'b1;
          end
        end
        ST_LOCK: begin
          if (stable == BTN_NONE) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    tmr_d = tmr_q;
    if (state_d != state_q || strobe) begin
      tmr_d = '0;
    end else if (tmr_q != '1) begin
      tmr_d = tmr_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_DN;
      tmr_q   <= '0;
      en_q    <= 1'b0;
      c_q     <= 1'b0;
      cu_q    <= 1'b0;
      cd_q    <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tmr_q   <= tmr_d;
      en_q    <= en;
      c_q     <= strobe;
      cu_q    <= strobe && (dir_d == DIR_UP);
      cd_q    <= strobe && (dir_d == DIR_DN);
      rpt_q   <= (state_d == ST_REPEAT);
    end
  end

  assign c   = c_q;
  assign cu  = cu_q;
  assign cd  = cd_q;
  assign rpt = rpt_q;

endmodule

// File: tb/tb_adjust_pulse_gen.sv
// Bench for adjust_pulse_gen: directed scenarios plus random
// button traffic against a timeline-based reference model.
module tb_adjust_pulse_gen;

  localparam int DB  = 4;
  localparam int HLD = 10;
  localparam int REP = 3;

  localparam int M_IDLE = 0;
  localparam int M_HELD = 1;
  localparam int M_LOCK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic btn_up = 1'b0;
  logic btn_dn = 1'b0;
  logic c, cu, cd, rpt;

  int n_err = 0;
  int n_chk = 0;

  logic [1:0] syn_hist[$];
  logic [1:0] m_raw_prev;
  logic [1:0] m_stable;
  int         m_mode;
  int         m_k;
  bit         m_up;
  bit         m_en_prev;
  logic [3:0] exp_o;

  adjust_pulse_gen #(
    .DB_CYCLES     (DB),
    .HOLD_CYCLES   (HLD),
    .REPEAT_CYCLES (REP),
    .CNT_BITS      (10)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
    .c      (c),
    .cu     (cu),
    .cd     (cd),
    .rpt    (rpt)
  );

  always #5 clk = ~clk;

  task automatic mdl_reset();
    syn_hist = {};
    for (int i = 0; i < DB; i++) syn_hist.push_back(2'b00);
    m_raw_prev = 2'b00;
    m_stable   = 2'b00;
    m_mode     = M_IDLE;
    m_k        = 0;
    m_up       = 1'b0;
    m_en_prev  = 1'b0;
    exp_o      = 4'b0000;
  endtask

  // syn_hist holds the synced vector of the last DB edges
  task automatic mdl_step();
    logic [1:0] sp;
    logic [1:0] snew;
    bit         all_eq;
    bit         e_c;
    bit         e_rpt;
    all_eq = 1'b1;
    for (int i = 0; i < DB; i++)
      if (syn_hist[i] != syn_hist[DB-1]) all_eq = 1'b0;
    snew = all_eq ? syn_hist[DB-1] : m_stable;
    void'(syn_hist.pop_front());
    syn_hist.push_back(m_raw_prev);
    m_raw_prev = {btn_up, btn_dn};
    sp = m_stable;
    m_stable = snew;
    e_c = 1'b0;
    e_rpt = 1'b0;
    if (!en) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (sp != 2'b00) begin
        if (!m_en_prev || sp == 2'b11) begin
          m_mode = M_LOCK;
        end else begin
          m_mode = M_HELD;
          m_up = (sp == 2'b10);
          m_k = 0;
          e_c = 1'b1;
        end
      end
    end else if (m_mode == M_HELD) begin
      if (sp == 2'b00) begin
        m_mode = M_IDLE;
      end else if (sp != (m_up ? 2'b10 : 2'b01)) begin
        m_mode = M_LOCK;
      end else begin
        m_k++;
        if (m_k == HLD || (m_k > HLD && (m_k - HLD) % REP == 0))
          e_c = 1'b1;
        e_rpt = (m_k >= HLD);
      end
    end else begin
      if (sp == 2'b00) m_mode = M_IDLE;
    end
    m_en_prev = en;
    exp_o = {e_c, e_c && m_up, e_c && !m_up, e_rpt};
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) mdl_reset();
    else mdl_step();
    #1;
  endtask

  task automatic test_reset();
    mdl_reset();
    #1;
    n_chk++;
    if ({c, cu, cd, rpt} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_async got=%b want=0000", {c, cu, cd, rpt});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({c, cu, cd, rpt} !== exp_o) begin
        n_err++;
        $display("FAIL reset_hold got=%b want=%b", {c, cu, cd, rpt}, exp_o);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if ({c, cu, cd, rpt} !== exp_o) begin
        n_err++;
        $display("FAIL reset_idle got=%b want=%b", {c, cu, cd, rpt}, exp_o);
      end
    end
  endtask

  task automatic test_single_press();
    int nst = 0;
    int first = -1;
    logic [1:0] qual = 2'b00;
    btn_up = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      n_chk++;
      if ({c, cu, cd, rpt} !== exp_o) begin
        n_err++;
        $display("FAIL single t=%0t got=%b want=%b", $time, {c, cu, cd, rpt}, exp_o);
      end
      if (c) begin
        nst++;
        if (first < 0) begin
          first = i;
          qual = {cu, cd};
        end
      end
      if (i == 8) btn_up = 1'b0;
    end
    n_chk++;
    if (nst != 1 || first != 7 || qual != 2'b10) begin
      n_err++;
      $display("FAIL single_timing got n=%0d at=%0d q=%b want n=1 at=7 q=10", nst, first, qual);
    end
  endtask

  task automatic test_repeat();
    int st[$];
    logic rpt2 = 1'b0;
    btn_dn = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      n_chk++;
      if ({c, cu, cd, rpt} !== exp_o) begin
        n_err++;
        $display("FAIL repeat t=%0t got=%b want=%b", $time, {c, cu, cd, rpt}, exp_o);
      end
      if (c) begin
        st.push_back(i);
        if (st.size() == 2) rpt2 = rpt;
      end
      if (i == 40) btn_dn = 1'b0;
    end
    // strobes at 7, 17, then every 3 up to 44; 47 loses to release
    n_chk++;
    if (st.size() != 11 || st[0] != 7 || st[1] != 17 || st[2] != 20 || st[10] != 44) begin
      n_err++;
      $display("FAIL repeat_timing got n=%0d want n=11 first=7 second=17 last=44", st.size());
    end
    n_chk++;
    if (rpt2 !== 1'b1) begin
      n_err++;
      $display("FAIL repeat_rpt got=%b want=1", rpt2);
    end
  endtask

  task automatic test_toggle();
    int nst = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i <= 20) btn_up = ((i - 1) % 4) < 2;
      else btn_up = 1'b0;
      tick();
      n_chk++;
      if ({c, cu, cd, rpt} !== exp_o) begin
        n_err++;
        $display("FAIL toggle t=%0t got=%b want=%b", $time, {c, cu, cd, rpt}, exp_o);
      end
      if (c) nst++;
    end
    n_chk++;
    if (nst != 0) begin
      n_err++;
      $display("FAIL toggle_count got=%0d want=0", nst);
    end
  endtask

  task automatic test_lock();
    int nst = 0;
    int first = -1;
    btn_up = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      n_chk++;
      if ({c, cu, cd, rpt} !== exp_o) begin
        n_err++;
        $display("FAIL lock t=%0t got=%b want=%b", $time, {c, cu, cd, rpt}, exp_o);
      end
      if (c) nst++;
      if (i == 8) btn_dn = 1'b1;
      if (i == 30) {btn_up, btn_dn} = 2'b00;
    end
    n_chk++;
    if (nst != 1) begin
      n_err++;
      $display("FAIL lock_count got=%0d want=1", nst);
    end
    btn_up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_chk++;
      if ({c, cu, cd, rpt} !== exp_o) begin
        n_err++;
        $display("FAIL lock_repress t=%0t got=%b want=%b", $time, {c, cu, cd, rpt}, exp_o);
      end
      if (c && first < 0) first = i;
    end
    btn_up = 1'b0;
    n_chk++;
    if (first != 7) begin
      n_err++;
      $display("FAIL lock_repress_at got=%0d want=7", first);
    end
    for (int i = 0; i < 15; i++) tick();
  endtask

  task automatic test_enable();
    int nst = 0;
    int first = -1;
    en = 1'b0;
    btn_up = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      if (i == 31) en = 1'b1;
      tick();
      n_chk++;
      if ({c, cu, cd, rpt} !== exp_o) begin
        n_err++;
        $display("FAIL enable t=%0t got=%b want=%b", $time, {c, cu, cd, rpt}, exp_o);
      end
      if (c) nst++;
    end
    n_chk++;
    if (nst != 0) begin
      n_err++;
      $display("FAIL enable_count got=%0d want=0", nst);
    end
    btn_up = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    btn_up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_chk++;
      if ({c, cu, cd, rpt} !== exp_o) begin
        n_err++;
        $display("FAIL enable_repress t=%0t got=%b want=%b", $time, {c, cu, cd, rpt}, exp_o);
      end
      if (c && first < 0) first = i;
    end
    btn_up = 1'b0;
    n_chk++;
    if (first != 7) begin
      n_err++;
      $display("FAIL enable_repress_at got=%0d want=7", first);
    end
    for (int i = 0; i < 15; i++) tick();
  endtask

  task automatic test_rst_mid();
    int first = -1;
    logic cd_first = 1'b0;
    btn_dn = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      tick();
      n_chk++;
      if ({c, cu, cd, rpt} !== exp_o) begin
        n_err++;
        $display("FAIL rstmid_pre t=%0t got=%b want=%b", $time, {c, cu, cd, rpt}, exp_o);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({c, cu, cd, rpt} !== 4'b0000) begin
      n_err++;
      $display("FAIL rstmid_async got=%b want=0000", {c, cu, cd, rpt});
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_chk++;
      if ({c, cu, cd, rpt} !== exp_o) begin
        n_err++;
        $display("FAIL rstmid_post t=%0t got=%b want=%b", $time, {c, cu, cd, rpt}, exp_o);
      end
      if (c && first < 0) begin
        first = i;
        cd_first = cd;
      end
    end
    btn_dn = 1'b0;
    n_chk++;
    if (first != 7 || cd_first !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_first got at=%0d cd=%b want at=7 cd=1", first, cd_first);
    end
    for (int i = 0; i < 15; i++) tick();
  endtask

  task automatic test_random();
    int dur;
    for (int s = 0; s < 70; s++) begin
      {btn_up, btn_dn} = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 7) != 0);
      dur = $urandom_range(1, 45);
      for (int i = 0; i < dur; i++) begin
        tick();
        n_chk++;
        if ({c, cu, cd, rpt} !== exp_o) begin
          n_err++;
          $display("FAIL random t=%0t got=%b want=%b", $time, {c, cu, cd, rpt}, exp_o);
        end
      end
    end
    {btn_up, btn_dn} = 2'b00;
    en = 1'b1;
    for (int i = 0; i < 15; i++) tick();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_repeat();
    test_toggle();
    test_lock();
    test_enable();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
